// File: rtl/radix4_mac.sv
// Radix-4 shift-and-add multiply-accumulate: P = A*B + C, unsigned.
// Processes two multiplier bits per CALC cycle, MSB-first, then folds in C.
module radix4_mac #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [W-1:0]   C,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] P
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      ACCUM = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam int            CW   = $clog2(W/2) + 1;
   localparam logic [CW-1:0] LAST = CW'(W/2 - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [2*W-1:0]   r_acc;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [W-1:0]     r_c;
   logic             r_busy;
   logic             r_done;
   logic [2*W-1:0]   r_p;

   logic [1:0]       w_digit;
   logic [2*W-1:0]   w_b_ext;
   logic [2*W-1:0]   w_mult;
   logic [2*W-1:0]   w_acc_step;
   logic [2*W-1:0]   w_acc_sum;

   assign w_digit = r_a[W-1:W-2];
   assign w_b_ext = {{W{1'b0}}, r_b};

   // Digit multiples from shifts and one add; 3*B still fits well inside 2W bits.
   always_comb begin
      w_mult = '0;
      case (w_digit)
         2'd0: w_mult = '0;
         2'd1: w_mult = w_b_ext;
         2'd2: w_mult = w_b_ext << 1;
         2'd3: w_mult = (w_b_ext << 1) + w_b_ext;
         default: w_mult = '0;
      endcase
   end

   assign w_acc_step = (r_acc << 2) + w_mult;
   assign w_acc_sum  = r_acc + {{W{1'b0}}, r_c};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_p     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_c     <= C;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_acc <= w_acc_step;
               r_a   <= r_a << 2;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_state <= ACCUM;
               end
            end
            ACCUM: begin
               r_acc   <= w_acc_sum;
               r_p     <= w_acc_sum;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign P    = r_p;

endmodule

// File: tb/tb_radix4_mac.sv
// Bench for radix4_mac: directed vectors with literal results, plus a cycle-level
// reference model (operation age counter and plain A*B+C) checked every cycle.
module tb_radix4_mac;
   localparam int W = 8;

   logic           clk;
   logic           resetn;
   logic           start;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [W-1:0]   C;
   logic           busy;
   logic           done;
   logic [2*W-1:0] P;

   int total;
   int bad;
   logic chk_en;

   radix4_mac #(.W(W)) dut (
      .clk   (clk),
      .resetn(resetn),
      .start (start),
      .A     (A),
      .B     (B),
      .C     (C),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an operation lasts W/2+2 cycles after its start edge;
   // the result appears on the (W/2+1)-th edge after acceptance.
   logic           m_active;
   int             m_age;
   logic [2*W-1:0] m_res;
   logic [2*W-1:0] m_p;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_active <= 1'b0;
         m_age    <= 0;
         m_res    <= '0;
         m_p      <= '0;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1'b1;
            m_age    <= 0;
            m_res    <= (2*W)'(int'(A) * int'(B) + int'(C));
         end
      end else begin
         m_age <= m_age + 1;
         if (m_age + 1 == W/2 + 1) m_p <= m_res;
         if (m_age + 1 == W/2 + 2) m_active <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_busy;
         logic exp_done;
         exp_busy = m_active && (m_age <= W/2);
         exp_done = m_active && (m_age == W/2 + 1);
         total++;
         if (busy !== exp_busy || done !== exp_done || P !== m_p) begin
            bad++;
            $display("FAIL model_cycle t=%0t busy=%b/%b done=%b/%b P=%h/%h (actual/required)",
                     $time, busy, exp_busy, done, exp_done, P, m_p);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Start one operation and check latency, busy length, result and single done pulse.
   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [2*W-1:0] exp_p);
      int edges;
      int busy_cnt;
      A = a; B = b; C = c; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges = 1;
      busy_cnt = busy ? 1 : 0;
      while (!done && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
         if (busy) busy_cnt++;
      end
      check({name, "_latency"}, edges, W/2 + 2);
      check({name, "_busy_cycles"}, busy_cnt, W/2 + 1);
      check({name, "_P"}, P, exp_p);
      $display("op %s: A=%h B=%h C=%h P=%h edges=%0d", name, a, b, c, P, edges);
      @(posedge clk);
      #1;
      check({name, "_done_single"}, done, 0);
   endtask

   initial begin
      int dcount;
      logic [7:0] n;
      logic [7:0] d;
      total = 0; bad = 0; chk_en = 1'b0;
      start = 1'b0; A = '0; B = '0; C = '0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #1;
      check("reset_P", P, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      run_op("basic", 8'h2D, 8'h07, 8'h03, 16'h013E);
      run_op("max", 8'hFF, 8'hFF, 8'hFF, 16'hFF00);
      run_op("zeroA", 8'h00, 8'hAB, 8'h00, 16'h0000);

      // Re-pulse during CALC with new operands must be ignored.
      A = 8'h12; B = 8'h34; C = 8'h56; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      A = 8'hFF; B = 8'hFF; C = 8'hFF; start = 1'b1;
      @(posedge clk); @(posedge clk); #1; start = 1'b0;
      dcount = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      check("restart_done_count", dcount, 1);
      check("restart_P", P, 16'h03FE);
      $display("op restart_ignored: P=%h dones=%0d", P, dcount);

      // Asynchronous reset mid-CALC, then an immediate new start.
      A = 8'h9C; B = 8'h3B; C = 8'h11; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk); #2;
      resetn = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_P", P, 0);
      check("abort_done", done, 0);
      $display("op abort: busy=%b P=%h", busy, P);
      @(posedge clk); @(posedge clk);
      @(negedge clk); #1;
      resetn = 1'b1;
      run_op("after_reset", 8'h0A, 8'h0B, 8'h05, 16'h0073);

      // start held high: back-to-back operations, one done every W/2+3 cycles.
      A = 8'h81; B = 8'h42; C = 8'h07; start = 1'b1;
      dcount = 0;
      for (int i = 0; i < 3 * (W/2 + 3); i++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      start = 1'b0;
      check("b2b_done_count", dcount, 3);
      check("b2b_P", P, 16'h2149);
      $display("op back_to_back: P=%h dones=%0d", P, dcount);
      repeat (W/2 + 4) @(posedge clk);
      #1;

      // Divider reconstruction: quotient*divisor + remainder gives the dividend back.
      for (int k = 0; k < 16; k++) begin
         n = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(64, 255));
         run_op("recon", n / d, d, n % d, {8'h00, n});
         check("recon_low", P[7:0], n);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d", total);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/radix4_mac.md
RADIX4_MAC -- requirements
Module: radix4_mac

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width; W SHALL be even and at least 4.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 Port A, input, W bits: multiplier, unsigned; a quotient word from the divider.
REQ-006 Port B, input, W bits: multiplicand, unsigned; the divisor.
REQ-007 Port C, input, W bits: addend, unsigned; the remainder.
REQ-008 Port busy, output, 1 bit: high in CALC and ACCUM states.
REQ-009 Port done, output, 1 bit: single-cycle pulse; high only in DONE state.
REQ-010 Port P, output, 2W bits: registered result P = A*B + C, unsigned; never tri-stated.

Function
REQ-011 The block SHALL have four states: IDLE=2'b00, CALC=2'b01, ACCUM=2'b10, DONE=2'b11.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL:
- latch A, B and C into internal registers;
- clear the accumulator and the iteration counter;
- enter CALC.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-014 The block SHALL process A MSB-first in radix-4 digits d = Areg[W-1:W-2], where d is in {0,1,2,3}.
REQ-015 Each CALC cycle SHALL perform, on one edge:
- acc <= (acc << 2) + d*Breg;
- Areg <= Areg << 2;
- counter <= counter + 1.
REQ-016 The digit multiples SHALL be formed as 0, Breg, Breg<<1, and (Breg<<1)+Breg, using no general multiplier.
REQ-017 The accumulator SHALL be 2W bits wide; the arithmetic SHALL be unsigned with no overflow for any input, since the maximum is (2^W-1)^2 + 2^W-1 < 2^(2W).
REQ-018 After exactly W/2 CALC cycles (4 when W=8), the state SHALL become ACCUM.
REQ-019 ACCUM SHALL take one cycle: acc <= acc + zero-extended Creg, and P <= acc + zero-extended Creg on the same edge; the state SHALL then become DONE.
REQ-020 DONE SHALL last one cycle; done=1 during it, then the state SHALL return to IDLE unconditionally.
REQ-021 Latency: if start is sampled at edge 1, done SHALL be high between edges W/2+2 and W/2+3 (edges 6-7 when W=8), with P valid from edge W/2+2.
REQ-022 P SHALL hold its value from ACCUM until the next ACCUM or reset; changes to A, B or C after the start edge SHALL NOT affect the result.
REQ-023 start while busy or in DONE SHALL be ignored: no restart and no queuing.
REQ-024 start held high continuously SHALL produce back-to-back operations, each beginning with the IDLE cycle that follows DONE.
REQ-025 Unreachable state encodings SHALL NOT exist; a two-bit state register covers all four codes.

Reset
REQ-026 resetn=0 SHALL immediately, without waiting for clk, clear:
- state to IDLE;
- counter, acc, Areg, Breg and Creg to 0;
- P to 0;
- busy and done to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow, and P SHALL read 0.
REQ-028 After resetn deasserts, the first rising edge SHALL be able to accept start.

Verification (W=8)
REQ-029 The bench SHALL cover this case: A=0x2D (45), B=0x07, C=0x03, start pulse -> done exactly 6 edges later, P=0x013E (318); busy high 5 cycles.
REQ-030 The bench SHALL cover this case: A=0xFF, B=0xFF, C=0xFF -> P=0xFF00 (65280); no overflow.
REQ-031 The bench SHALL cover this case: A=0x00, B=0xAB, C=0x00 -> P=0x0000; done still pulses at the 6-edge latency.
REQ-032 The bench SHALL cover this case: start re-pulsed during CALC with different operands -> ignored; P equals the result of the first operands; one done pulse only.
REQ-033 The bench SHALL cover this case: resetn pulled low mid-CALC, asynchronously between edges -> busy=0 and P=0 before the next edge; no done; a new start then computes normally.
REQ-034 The bench SHALL cover this case: reconstruction sweep feeding divider outputs, with A=quotient, B=divisor, C=remainder, over random N and D with D in [0x40,0xFF] -> P[7:0] equals N for every pair.
